register_file: RTL and testbench
================================

# register_file

Architectural register file with per-register rename tags; the receiving end of the reorder buffer's commit port and the operand source for the dispatcher. Holds 32 × 32-bit values plus a RoB-index tag per register. Commits from the reorder buffer write values and retire tags. Dispatch renames claim tags. A misprediction flush drops every outstanding tag.

## Interface
- REG_WIDTH, 5, architectural register index width
- EX_REG_WIDTH, 6, register index width with extra bit; value NON_REG means "no register"
- NON_REG, 32, encoding for absent rs/rd
- RoB_WIDTH, 4, RoB index width
- EX_RoB_WIDTH, 5, tag width; extra bit encodes no dependency
- NON_DEP, 16, tag value meaning "value is architectural, no pending producer"

Ports:
- Sys_clk  in  1  clock, all state on rising edge
- Sys_rst  in  1  reset, asynchronous, active-high
- Sys_rdy  in  1  global enable; low freezes all state
- DPRF_rs1  in  EX_REG_WIDTH  source register 1 lookup
- DPRF_rs2  in  EX_REG_WIDTH  source register 2 lookup
- RFDP_Qj  out  EX_RoB_WIDTH  producer tag for rs1, or NON_DEP
- RFDP_Qk  out  EX_RoB_WIDTH  producer tag for rs2, or NON_DEP
- RFDP_Vj  out  32  value for rs1; valid when RFDP_Qj == NON_DEP
- RFDP_Vk  out  32  value for rs2; valid when RFDP_Qk == NON_DEP
- DPRF_en  in  1  rename request this cycle
- DPRF_rd  in  EX_REG_WIDTH  destination being renamed
- DPRF_RoB_index  in  RoB_WIDTH  RoB entry that will produce DPRF_rd
- RoBRF_pre_judge  in  1  0 = misprediction flush
- RoBRF_en  in  1  commit valid
- RoBRF_RoB_index  in  RoB_WIDTH  committing RoB entry
- RoBRF_rd  in  EX_REG_WIDTH  committing destination
- RoBRF_value  in  32  committed value

## Operation
- **State:**
  - value[0..31], 32 bits each.
  - tag[0..31], EX_RoB_WIDTH bits each.
- **Reset:**
  - All value = 0 and all tag = NON_DEP.
  - Outputs are combinational; after reset they read Q = 16 and V = 0.
- **Invalid register:** x0, or any index ≥ 32 (NON_REG).
  - Reads return Q = NON_DEP and V = 0.
  - Commits and renames to it are ignored.
- **Commit** (Sys_rdy & RoBRF_en, valid rd):
  - value[rd] ← RoBRF_value.
  - If tag[rd] == {0, RoBRF_RoB_index}, then tag[rd] ← NON_DEP.
  - A mismatched tag means a younger rename exists; that tag is kept.
- **Rename** (Sys_rdy & DPRF_en & RoBRF_pre_judge, valid rd):
  - tag[DPRF_rd] ← {0, DPRF_RoB_index}.
- **Commit and rename to the same rd in one cycle:**
  - The value is written.
  - The tag takes the rename; the rename wins over the tag clear.
- **Flush** (Sys_rdy & !RoBRF_pre_judge):
  - All tags ← NON_DEP.
  - A commit in the same cycle still writes its value.
  - DPRF_en is ignored.
  - Values are never cleared by a flush.
- **Read bypass** (per port, combinational). Applies when Sys_rdy & RoBRF_en & RoBRF_rd == rs & tag[rs] == {0, RoBRF_RoB_index}:
  - Q = NON_DEP and V = RoBRF_value.
  - Otherwise Q = tag[rs] and V = value[rs].
- **Read vs. rename ordering:** reads reflect pre-edge state.
  - An instruction with rs == rd sees the older producer, not itself.

## Timing
- Read ports have zero latency (combinational from DPRF_rs*, tag/value arrays and the commit bus).
- Commit value and tag clear are visible from the cycle after the edge; same-cycle visibility comes via the bypass.
- A rename is visible on the read ports one cycle after DPRF_en.
- A flush takes effect at the edge where RoBRF_pre_judge == 0 is sampled; the next cycle reads all NON_DEP.
- Sys_rdy low: no state change and no bypass.
- Asynchronous Sys_rst mid-operation: state cleared immediately, independent of Sys_clk and Sys_rdy.

## Structure
- **Shared package:** REG_WIDTH, EX_REG_WIDTH, NON_REG, RoB_WIDTH, EX_RoB_WIDTH, NON_DEP. These are shared with the reorder buffer, dispatcher and reservation station.
- **Sub-module:** register_file_read_port, instantiated twice.
  - Inputs: rs, tag/value of rs, and the commit bus.
  - Performs the invalid-register check and the bypass mux.
- The top level holds the arrays and the update logic.

## Test plan
- Reset, then read rs1 = 5, rs2 = 0 → Qj = 16, Vj = 0, Qk = 16, Vk = 0.
- Rename x5 → RoB 3; next cycle read x5 → Qj = 3. Commit rd = 5, idx 3, value 0xDEADBEEF → same-cycle Qj = 16, Vj = 0xDEADBEEF. Next cycle: tag 16, value held.
- Rename x7 → 2, then x7 → 9; commit rd = 7, idx 2, value 0x11 → value[7] = 0x11, Q stays 9.
- Same cycle: commit rd = 4 idx 1 (tag 1) and rename x4 → 6 → value written, tag = 6.
- Renames on x1, x2, x3 pending, then RoBRF_pre_judge = 0 with a commit rd = 1 value 0x55 and DPRF_en on x8 → all tags 16, value[1] = 0x55, x8 not renamed.
- Rename/commit to rd = 0 and rd = 32 → no state change; x0 reads 0. Sys_rdy = 0 with commit → no change. Async Sys_rst between edges → immediate clear.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared widths, encodings and helpers for the register file, reorder buffer,
// dispatcher and reservation station.
package register_file_pkg;

  localparam int unsigned REG_WIDTH    = 5;
  localparam int unsigned EX_REG_WIDTH = 6;
  localparam int unsigned RoB_WIDTH    = 4;
  localparam int unsigned EX_RoB_WIDTH = 5;
  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned NUM_REGS     = 32;

  localparam logic [EX_REG_WIDTH-1:0] NON_REG = EX_REG_WIDTH'(32);
  localparam logic [EX_RoB_WIDTH-1:0] NON_DEP = EX_RoB_WIDTH'(16);

  typedef logic [EX_REG_WIDTH-1:0] reg_idx_t;
  typedef logic [RoB_WIDTH-1:0]    rob_idx_t;
  typedef logic [EX_RoB_WIDTH-1:0] tag_t;
  typedef logic [DATA_WIDTH-1:0]   value_t;

  // Commit bus from the reorder buffer, as seen by the read-port bypass.
  typedef struct packed {
    logic     en;
    rob_idx_t rob_index;
    reg_idx_t rd;
    value_t   value;
  } commit_t;

  // x0 and anything at or above NON_REG hold no architectural state.
  function automatic logic reg_valid(input reg_idx_t r);
    return (r < NON_REG) && (r != '0);
  endfunction

  // Tag naming a live RoB producer; the cleared top bit distinguishes it from NON_DEP.
  function automatic tag_t rob_tag(input rob_idx_t idx);
    return {1'b0, idx};
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Dispatch lookup/rename and RoB commit signals of the register file.
interface register_file_if;
  import register_file_pkg::*;

  reg_idx_t DPRF_rs1;
  reg_idx_t DPRF_rs2;
  tag_t     RFDP_Qj;
  tag_t     RFDP_Qk;
  value_t   RFDP_Vj;
  value_t   RFDP_Vk;
  logic     DPRF_en;
  reg_idx_t DPRF_rd;
  rob_idx_t DPRF_RoB_index;
  logic     RoBRF_pre_judge;
  logic     RoBRF_en;
  rob_idx_t RoBRF_RoB_index;
  reg_idx_t RoBRF_rd;
  value_t   RoBRF_value;

  modport master (
    output DPRF_rs1, DPRF_rs2, DPRF_en, DPRF_rd, DPRF_RoB_index,
    output RoBRF_pre_judge, RoBRF_en, RoBRF_RoB_index, RoBRF_rd, RoBRF_value,
    input  RFDP_Qj, RFDP_Qk, RFDP_Vj, RFDP_Vk
  );

  modport slave (
    input  DPRF_rs1, DPRF_rs2, DPRF_en, DPRF_rd, DPRF_RoB_index,
    input  RoBRF_pre_judge, RoBRF_en, RoBRF_RoB_index, RoBRF_rd, RoBRF_value,
    output RFDP_Qj, RFDP_Qk, RFDP_Vj, RFDP_Vk
  );
endinterface

// File: rtl/register_file_read_port.sv
// One operand lookup: invalid-register masking plus same-cycle commit bypass.
module register_file_read_port
  import register_file_pkg::*;
(
  input  logic     rdy,
  input  reg_idx_t rs,
  input  tag_t     tag,
  input  value_t   value,
  input  commit_t  commit,
  output tag_t     q_c,
  output value_t   v_c
);

  // A commit retiring the very producer we depend on is forwarded directly.
  always_comb begin
    q_c = NON_DEP;
    v_c = '0;
    if (reg_valid(rs)) begin
      if (rdy && commit.en && (commit.rd == rs) && (tag == rob_tag(commit.rob_index))) begin
        q_c = NON_DEP;
        v_c = commit.value;
      end else begin
        q_c = tag;
        v_c = value;
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file: 32 values with per-register RoB rename tags.
module register_file
  import register_file_pkg::*;
(
  input logic            Sys_clk,
  input logic            Sys_rst,
  input logic            Sys_rdy,
  register_file_if.slave bus
);

  tag_t     tags   [NUM_REGS];
  value_t   values [NUM_REGS];
  commit_t  commit;
  logic     commit_hit;
  logic     rename_hit;
  logic     flush;
  logic [REG_WIDTH-1:0] c_idx;
  logic [REG_WIDTH-1:0] r_idx;
  logic [REG_WIDTH-1:0] rs1_idx;
  logic [REG_WIDTH-1:0] rs2_idx;

  // Decode the commit, rename and flush requests for this cycle.
  always_comb begin
    commit     = '{en: bus.RoBRF_en, rob_index: bus.RoBRF_RoB_index,
                   rd: bus.RoBRF_rd, value: bus.RoBRF_value};
    c_idx      = bus.RoBRF_rd[REG_WIDTH-1:0];
    r_idx      = bus.DPRF_rd[REG_WIDTH-1:0];
    rs1_idx    = bus.DPRF_rs1[REG_WIDTH-1:0];
    rs2_idx    = bus.DPRF_rs2[REG_WIDTH-1:0];
    flush      = Sys_rdy && !bus.RoBRF_pre_judge;
    commit_hit = Sys_rdy && bus.RoBRF_en && reg_valid(bus.RoBRF_rd);
    rename_hit = Sys_rdy && bus.DPRF_en && bus.RoBRF_pre_judge && reg_valid(bus.DPRF_rd);
  end

  // State update; later assignments win, so flush and rename override the commit tag clear.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        tags[REG_WIDTH'(i)]   <= NON_DEP;
        values[REG_WIDTH'(i)] <= '0;
      end
    end else if (Sys_rdy) begin
      if (commit_hit) begin
        values[c_idx] <= bus.RoBRF_value;
        if (tags[c_idx] == rob_tag(bus.RoBRF_RoB_index)) begin
          tags[c_idx] <= NON_DEP;
        end
      end
      if (flush) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          tags[REG_WIDTH'(i)] <= NON_DEP;
        end
      end else if (rename_hit) begin
        tags[r_idx] <= rob_tag(bus.DPRF_RoB_index);
      end
    end
  end

  register_file_read_port u_read_j (
    .rdy    (Sys_rdy),
    .rs     (bus.DPRF_rs1),
    .tag    (tags[rs1_idx]),
    .value  (values[rs1_idx]),
    .commit (commit),
    .q_c    (bus.RFDP_Qj),
    .v_c    (bus.RFDP_Vj)
  );

  register_file_read_port u_read_k (
    .rdy    (Sys_rdy),
    .rs     (bus.DPRF_rs2),
    .tag    (tags[rs2_idx]),
    .value  (values[rs2_idx]),
    .commit (commit),
    .q_c    (bus.RFDP_Qk),
    .v_c    (bus.RFDP_Vk)
  );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: directed vectors queue their expected
// read-port values, a negedge monitor pops and compares.
module tb_register_file;
  import register_file_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;
  logic chk = 1'b0;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [4:0]  qj;
    logic [31:0] vj;
    logic [4:0]  qk;
    logic [31:0] vk;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  register_file_if bus();

  register_file dut (
    .Sys_clk (clk),
    .Sys_rst (rst),
    .Sys_rdy (rdy),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Monitor: the read ports are valid whenever the stimulus marks a cycle as checked.
  always @(negedge clk) begin
    if (chk) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_read: DUT presented a read with no queued expectation");
      end else begin
        exp_t  e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        vectors++;
        if (bus.RFDP_Qj !== e.qj || bus.RFDP_Vj !== e.vj ||
            bus.RFDP_Qk !== e.qk || bus.RFDP_Vk !== e.vk) begin
          miscompares++;
          $display("FAIL %s: got Qj=%0d Vj=%h Qk=%0d Vk=%h, expected Qj=%0d Vj=%h Qk=%0d Vk=%h",
                   n, bus.RFDP_Qj, bus.RFDP_Vj, bus.RFDP_Qk, bus.RFDP_Vk,
                   e.qj, e.vj, e.qk, e.vk);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    chk                 = 1'b0;
    rdy                 = 1'b1;
    bus.DPRF_rs1        = '0;
    bus.DPRF_rs2        = '0;
    bus.DPRF_en         = 1'b0;
    bus.DPRF_rd         = '0;
    bus.DPRF_RoB_index  = '0;
    bus.RoBRF_pre_judge = 1'b1;
    bus.RoBRF_en        = 1'b0;
    bus.RoBRF_RoB_index = '0;
    bus.RoBRF_rd        = '0;
    bus.RoBRF_value     = '0;
  endtask

  task automatic rename(input logic [5:0] rd, input logic [3:0] idx);
    bus.DPRF_en        = 1'b1;
    bus.DPRF_rd        = rd;
    bus.DPRF_RoB_index = idx;
  endtask

  task automatic commit(input logic [5:0] rd, input logic [3:0] idx, input logic [31:0] val);
    bus.RoBRF_en        = 1'b1;
    bus.RoBRF_rd        = rd;
    bus.RoBRF_RoB_index = idx;
    bus.RoBRF_value     = val;
  endtask

  task automatic expect_rd(input string n, input logic [5:0] r1, input logic [5:0] r2,
                           input logic [4:0] qj, input logic [31:0] vj,
                           input logic [4:0] qk, input logic [31:0] vk);
    exp_t e;
    bus.DPRF_rs1 = r1;
    bus.DPRF_rs2 = r2;
    e.qj = qj; e.vj = vj; e.qk = qk; e.vk = vk;
    exp_q.push_back(e);
    name_q.push_back(n);
    chk = 1'b1;
  endtask

  initial begin
    next_cycle();
    rdy = 1'b0;
    next_cycle();
    rst = 1'b0;

    // Reset state
    expect_rd("reset_read", 6'd5, 6'd0, 5'd16, 32'h0, 5'd16, 32'h0);

    // Rename x5 -> 3, commit it with bypass
    next_cycle(); rename(6'd5, 4'd3);
    expect_rd("rename_same_cycle", 6'd5, 6'd0, 5'd16, 32'h0, 5'd16, 32'h0);
    next_cycle();
    expect_rd("rename_visible", 6'd5, 6'd5, 5'd3, 32'h0, 5'd3, 32'h0);
    next_cycle(); commit(6'd5, 4'd3, 32'hDEADBEEF);
    expect_rd("commit_bypass", 6'd5, 6'd6, 5'd16, 32'hDEADBEEF, 5'd16, 32'h0);
    next_cycle();
    expect_rd("commit_held", 6'd5, 6'd0, 5'd16, 32'hDEADBEEF, 5'd16, 32'h0);

    // Younger rename survives an older commit
    next_cycle(); rename(6'd7, 4'd2);
    next_cycle(); rename(6'd7, 4'd9);
    expect_rd("first_rename_x7", 6'd7, 6'd0, 5'd2, 32'h0, 5'd16, 32'h0);
    next_cycle(); commit(6'd7, 4'd2, 32'h11);
    expect_rd("stale_commit_no_bypass", 6'd7, 6'd5, 5'd9, 32'h0, 5'd16, 32'hDEADBEEF);
    next_cycle();
    expect_rd("stale_commit_keeps_tag", 6'd7, 6'd0, 5'd9, 32'h11, 5'd16, 32'h0);

    // Commit and rename to the same rd
    next_cycle(); rename(6'd4, 4'd1);
    next_cycle(); commit(6'd4, 4'd1, 32'h44); rename(6'd4, 4'd6);
    expect_rd("commit_rename_bypass", 6'd4, 6'd4, 5'd16, 32'h44, 5'd16, 32'h44);
    next_cycle();
    expect_rd("rename_beats_clear", 6'd4, 6'd0, 5'd6, 32'h44, 5'd16, 32'h0);

    // Flush with a concurrent commit and an ignored rename
    next_cycle(); rename(6'd1, 4'd10);
    next_cycle(); rename(6'd2, 4'd11);
    next_cycle(); rename(6'd3, 4'd12);
    next_cycle();
    expect_rd("pending_before_flush", 6'd1, 6'd3, 5'd10, 32'h0, 5'd12, 32'h0);
    next_cycle(); bus.RoBRF_pre_judge = 1'b0;
    commit(6'd1, 4'd5, 32'h55); rename(6'd8, 4'd7);
    expect_rd("flush_cycle_reads_old", 6'd2, 6'd1, 5'd11, 32'h0, 5'd10, 32'h0);
    next_cycle();
    expect_rd("flush_commit_value", 6'd1, 6'd2, 5'd16, 32'h55, 5'd16, 32'h0);
    next_cycle();
    expect_rd("flush_no_rename_x8", 6'd3, 6'd8, 5'd16, 32'h0, 5'd16, 32'h0);
    next_cycle();
    expect_rd("flush_keeps_values", 6'd7, 6'd4, 5'd16, 32'h11, 5'd16, 32'h44);

    // Invalid registers x0 and NON_REG
    next_cycle(); rename(6'd0, 4'd5); commit(6'd32, 4'd0, 32'h99);
    expect_rd("invalid_regs_a", 6'd0, 6'd32, 5'd16, 32'h0, 5'd16, 32'h0);
    next_cycle(); rename(6'd32, 4'd5); commit(6'd0, 4'd3, 32'h77);
    expect_rd("invalid_regs_b", 6'd32, 6'd0, 5'd16, 32'h0, 5'd16, 32'h0);
    next_cycle();
    expect_rd("invalid_regs_after", 6'd0, 6'd33, 5'd16, 32'h0, 5'd16, 32'h0);

    // Sys_rdy low freezes state and disables the bypass
    next_cycle(); rename(6'd9, 4'd4);
    next_cycle(); rdy = 1'b0; bus.RoBRF_pre_judge = 1'b0;
    commit(6'd9, 4'd4, 32'hAB); rename(6'd10, 4'd5);
    expect_rd("rdy_low_no_bypass", 6'd9, 6'd10, 5'd4, 32'h0, 5'd16, 32'h0);
    next_cycle();
    expect_rd("rdy_low_no_change", 6'd9, 6'd10, 5'd4, 32'h0, 5'd16, 32'h0);

    // Asynchronous reset between edges
    next_cycle(); rdy = 1'b0;
    expect_rd("async_reset", 6'd5, 6'd9, 5'd16, 32'h0, 5'd16, 32'h0);
    #1 rst = 1'b1;
    next_cycle(); rst = 1'b0;
    expect_rd("after_reset", 6'd5, 6'd1, 5'd16, 32'h0, 5'd16, 32'h0);

    next_cycle();
    next_cycle();
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations never checked, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
